ps2_key_controller: RTL and testbench
=====================================

# ps2_key_controller

Sequences the PS/2 receive path for keyboard input. It sits directly downstream of the PS/2 frame receiver and owns that receiver's `rx_enable` input. It parses the byte stream as scan-code set 2: E0 extended prefix, F0 break prefix, and the E1 Pause sequence. It queues decoded key events in a FIFO with a valid/ready handshake. It throttles the receiver when the FIFO is full and recovers from broken prefix sequences by timeout.

## Interface
- `DEPTH`, 8: event FIFO depth; power of two, 2..64.
- `TIMEOUT`, 16'd50000: idle cycles allowed inside a prefix or skip sequence before abandoning it; must be ≥ 1.
- `clk` input 1: system clock, same clock as the receiver.
- `rst` input 1: asynchronous, active-high reset.
- `enable` input 1: master enable for keyboard reception.
- `rx_data` input 8: received byte from the receiver; valid when `rx_done_stb` = 1.
- `rx_done_stb` input 1: one-cycle pulse per completed frame.
- `rx_enable` output 1: to the receiver; `enable & ~full`; combinational.
- `ev_data` output 10: {ext, brk, code[7:0]} at the FIFO head.
- `ev_valid` output 1: FIFO not empty.
- `ev_ready` input 1: consumer accepts the head on a cycle where `ev_valid & ev_ready`.
- `ovf` output 1: sticky; an event was dropped because the FIFO was full.
- `err` output 1: sticky; the keyboard sent 0x00 or 0xFF (overrun), or a sequence timed out.
- `flag_clr` input 1: synchronous clear of `ovf` and `err`.

## Operation
- Parser FSM states: IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (E1 seen).
- Bytes are consumed only on `rx_done_stb`. In IDLE the byte is handled as follows:
  - E0 → EXT.
  - F0 → BRK.
  - E1 → SKIP, with skip count = 7.
  - 0x00/0xFF → set `err`, stay in IDLE.
  - Any other byte → push {0,0,byte}.
- EXT: F0 → EXT_BRK. E0 → stay in EXT. Any other byte → push {1,0,byte}, go to IDLE.
- BRK: any byte except E0/F0 → push {0,1,byte}, go to IDLE. E0/F0 → set `err`, go to IDLE.
- EXT_BRK: any byte → push {1,1,byte}, go to IDLE.
- SKIP: each byte decrements the skip count. When the count reaches 0, push {1,0,8'hE1} (Pause event) and go to IDLE.
- Timeout: a 16-bit counter loads `TIMEOUT` on every state entry and every strobe, and decrements each cycle while not in IDLE. When it reaches 0, set `err`, go to IDLE, push nothing.
- `enable` = 0 forces IDLE on the next edge. The FIFO contents and flags are retained.
- Bytes 0xAA, 0xFA, 0xFE, 0xEE in IDLE are treated as ordinary codes and queued. Filtering them is the consumer's job.
- FIFO behaviour:
  - Read/write pointers are log2(DEPTH)+1 bits wide.
  - `full` is true when the pointers differ only in their MSB. `empty` is true when the pointers are equal.
  - A push while full is dropped and sets `ovf`. This happens when a frame started before `rx_enable` fell.
  - A pop while empty is ignored.
  - Push and pop in the same cycle both succeed, including when full, so occupancy is unchanged and `ovf` is not set.
- `flag_clr` and a new flag event in the same cycle: the new event wins, and the flag stays 1.

## Timing
- After reset: FSM = IDLE, FIFO empty, `ev_valid` = 0, `ev_data` = 0, `ovf` = 0, `err` = 0, timeout counter = 0. `rx_enable` equals `enable` during and after reset.
- A strobe in cycle N writes the FIFO at edge N→N+1. `ev_valid` rises in cycle N+1. Latency is 1 clock.
- `ev_data` is the registered FIFO head, stable while `ev_valid` = 1 and not popped. The next entry appears the cycle after a pop.
- `rx_enable` falls in the same cycle `full` rises. It rises the cycle after a pop that clears `full`.
- `ovf` and `err` are registered; they assert the cycle after the causing strobe or timeout.
- Asserting `rst` mid-sequence or mid-FIFO returns all state to reset values immediately, without waiting for a clock edge.

## Test plan
- Strobes 1C; E0 75; F0 1C; E0 F0 75, each with `ev_ready` = 1 → events 0x01C, 0x275, 0x11C, 0x375 in order, each `ev_valid` one cycle after its final strobe.
- E1 14 77 E1 F0 14 F0 77 → exactly one event 0x2E1. No intermediate events.
- E0, then no strobe for `TIMEOUT` cycles, then 1C → `err` = 1, FSM in IDLE, then event 0x01C (ext = 0).
- `ev_ready` = 0, DEPTH+1 strobes of code 0x16 → `rx_enable` = 0 once DEPTH entries are present, last event dropped, `ovf` = 1. Draining yields exactly DEPTH × 0x016. `flag_clr` then sets `ovf` = 0.
- FIFO full, strobe 0x1E and pop in the same cycle → occupancy stays DEPTH, `ovf` stays 0, 0x01E is the last entry.
- `rst` pulsed between F0 and 1C → no event, then a strobe of 1C yields 0x01C. Also: strobe 0x00 → `err` = 1, no event.

Source files
------------

// File: rtl/ps2_key_controller_if.sv
// Bundles the PS/2 receive strobe side and the key-event handshake side.
// The controller takes the slave view; the system or bench takes the master view.
interface ps2_key_controller_if;
  logic       enable;
  logic [7:0] rx_data;
  logic       rx_done_stb;
  logic       rx_enable;
  logic [9:0] ev_data;
  logic       ev_valid;
  logic       ev_ready;
  logic       ovf;
  logic       err;
  logic       flag_clr;

  modport master (
    output enable, rx_data, rx_done_stb, ev_ready, flag_clr,
    input  rx_enable, ev_data, ev_valid, ovf, err
  );

  modport slave (
    input  enable, rx_data, rx_done_stb, ev_ready, flag_clr,
    output rx_enable, ev_data, ev_valid, ovf, err
  );
endinterface

// File: rtl/ps2_key_controller.sv
// Scan-code set 2 parser (E0/F0/E1 prefixes, timeout recovery) feeding a key-event FIFO.
// Event appears 1 clock after its final strobe; a full FIFO drops rx_enable and flags ovf on drops.
module ps2_key_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_vld,
  input  logic [WIDTH-1:0] wr_dat,
  output logic             wr_drop,
  input  logic             rd_rdy,
  output logic             rd_vld,
  output logic [WIDTH-1:0] rd_dat,
  output logic             full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr, rptr;
  logic             empty, do_wr, do_rd;

  assign empty   = (wptr == rptr);
  assign full    = ((wptr ^ rptr) == {1'b1, {AW{1'b0}}});
  assign do_rd   = rd_rdy & ~empty;
  // A pop in the same cycle frees the slot, so a write while full still lands.
  assign do_wr   = wr_vld & (~full | do_rd);
  assign wr_drop = wr_vld & full & ~do_rd;
  assign rd_vld  = ~empty;
  assign rd_dat  = empty ? '0 : mem[rptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[AW-1:0]] <= wr_dat;
  end
endmodule

module ps2_key_controller #(
  parameter int          DEPTH   = 8,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input logic                 clk,
  input logic                 rst,
  ps2_key_controller_if.slave bus
);
  typedef enum logic [2:0] {IDLE, EXT, BRK, EXT_BRK, SKIP} state_t;

  state_t      state, state_nxt;
  logic [2:0]  skip_cnt, skip_nxt;
  logic [15:0] tmo_cnt;
  logic        push_vld, push_drop, err_set, tmo_fire, full;
  logic [9:0]  push_dat;
  logic        ovf_q, err_q;

  // Fires on the cycle the counter would decrement to zero; a strobe takes priority.
  assign tmo_fire = bus.enable && (state != IDLE) && !bus.rx_done_stb && (tmo_cnt == 16'd1);

  always_comb begin
    state_nxt = state;
    skip_nxt  = skip_cnt;
    push_vld  = 1'b0;
    push_dat  = {2'b00, bus.rx_data};
    err_set   = 1'b0;
    if (!bus.enable) begin
      state_nxt = IDLE;
    end else if (bus.rx_done_stb) begin
      case (state)
        IDLE: begin
          case (bus.rx_data)
            8'hE0:        state_nxt = EXT;
            8'hF0:        state_nxt = BRK;
            8'hE1: begin
              state_nxt = SKIP;
              skip_nxt  = 3'd7;
            end
            8'h00, 8'hFF: err_set   = 1'b1;
            default:      push_vld  = 1'b1;
          endcase
        end
        EXT: begin
          if (bus.rx_data == 8'hF0) begin
            state_nxt = EXT_BRK;
          end else if (bus.rx_data != 8'hE0) begin
            push_vld  = 1'b1;
            push_dat  = {2'b10, bus.rx_data};
            state_nxt = IDLE;
          end
        end
        BRK: begin
          state_nxt = IDLE;
          if (bus.rx_data == 8'hE0 || bus.rx_data == 8'hF0) begin
            err_set = 1'b1;
          end else begin
            push_vld = 1'b1;
            push_dat = {2'b01, bus.rx_data};
          end
        end
        EXT_BRK: begin
          push_vld  = 1'b1;
          push_dat  = {2'b11, bus.rx_data};
          state_nxt = IDLE;
        end
        SKIP: begin
          if (skip_cnt == 3'd1) begin
            push_vld  = 1'b1;
            push_dat  = {2'b10, 8'hE1};
            state_nxt = IDLE;
          end else begin
            skip_nxt = skip_cnt - 3'd1;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end else if (tmo_fire) begin
      state_nxt = IDLE;
      err_set   = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      skip_cnt <= 3'd0;
    end else begin
      state    <= state_nxt;
      skip_cnt <= skip_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= 16'd0;
    end else if (bus.rx_done_stb || (state_nxt != state && !tmo_fire)) begin
      tmo_cnt <= TIMEOUT;
    end else if (state != IDLE) begin
      tmo_cnt <= tmo_cnt - 16'd1;
    end
  end

  // A new flag event outranks a simultaneous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      ovf_q <= push_drop ? 1'b1 : (bus.flag_clr ? 1'b0 : ovf_q);
      err_q <= err_set   ? 1'b1 : (bus.flag_clr ? 1'b0 : err_q);
    end
  end

  ps2_key_fifo #(.DEPTH(DEPTH), .WIDTH(10)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_vld  (push_vld),
    .wr_dat  (push_dat),
    .wr_drop (push_drop),
    .rd_rdy  (bus.ev_ready),
    .rd_vld  (bus.ev_valid),
    .rd_dat  (bus.ev_data),
    .full    (full)
  );

  assign bus.rx_enable = bus.enable & ~full;
  assign bus.ovf       = ovf_q;
  assign bus.err       = err_q;
endmodule

// File: tb/tb_ps2_key_controller.sv
// Directed bench for ps2_key_controller: event queue model checked every cycle, plus literal spot checks.
module tb_ps2_key_controller;
  localparam int          DEPTH = 8;
  localparam logic [15:0] TMO   = 16'd20;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ps2_key_controller_if kif();

  ps2_key_controller #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (kif)
  );

  int         checks = 0;
  int         errors = 0;
  logic [9:0] mq[$];
  logic       m_ovf = 1'b0;
  logic       m_err = 1'b0;
  logic       exp_push = 1'b0;
  logic [9:0] exp_dat = '0;
  logic       exp_err = 1'b0;
  bit         m_pop, m_full, m_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Model: a bounded queue of expected events with sticky flags.
  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        mq.delete();
        m_ovf = 1'b0;
        m_err = 1'b0;
      end else begin
        m_full = (mq.size() == DEPTH);
        m_pop  = kif.ev_ready && (mq.size() != 0);
        m_drop = 1'b0;
        if (m_pop) void'(mq.pop_front());
        if (exp_push) begin
          if (!m_full || m_pop) mq.push_back(exp_dat);
          else m_drop = 1'b1;
        end
        m_ovf = m_drop  ? 1'b1 : (kif.flag_clr ? 1'b0 : m_ovf);
        m_err = exp_err ? 1'b1 : (kif.flag_clr ? 1'b0 : m_err);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("ev_valid", kif.ev_valid, mq.size() != 0);
        if (mq.size() != 0) chk("ev_data", kif.ev_data, mq[0]);
        chk("rx_enable", kif.rx_enable, kif.enable && (mq.size() < DEPTH));
        chk("ovf", kif.ovf, m_ovf);
        chk("err", kif.err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] b, input bit push, input logic [9:0] d, input bit e);
    kif.rx_data     = b;
    kif.rx_done_stb = 1'b1;
    exp_push        = push;
    exp_dat         = d;
    exp_err         = e;
    tick();
    kif.rx_done_stb = 1'b0;
    exp_push        = 1'b0;
    exp_err         = 1'b0;
  endtask

  logic [7:0] code;

  initial begin
    rst             = 1'b1;
    kif.enable      = 1'b1;
    kif.rx_data     = 8'h00;
    kif.rx_done_stb = 1'b0;
    kif.ev_ready    = 1'b0;
    kif.flag_clr    = 1'b0;
    repeat (3) tick();
    chk("rst_ev_valid", kif.ev_valid, 1'b0);
    chk("rst_ev_data", kif.ev_data, 10'h000);
    chk("rst_ovf", kif.ovf, 1'b0);
    chk("rst_err", kif.err, 1'b0);
    chk("rst_rx_enable_hi", kif.rx_enable, 1'b1);
    kif.enable = 1'b0;
    #1;
    chk("rst_rx_enable_lo", kif.rx_enable, 1'b0);
    kif.enable = 1'b1;
    tick();
    rst = 1'b0;
    tick();

    // Make, extended make, break, extended break.
    kif.ev_ready = 1'b1;
    strobe(8'h1C, 1, 10'h01C, 0);
    chk("make_1c", kif.ev_data, 10'h01C);
    strobe(8'hE0, 0, 10'h0, 0);
    strobe(8'h75, 1, 10'h275, 0);
    chk("ext_75", kif.ev_data, 10'h275);
    strobe(8'hF0, 0, 10'h0, 0);
    strobe(8'h1C, 1, 10'h11C, 0);
    chk("brk_1c", kif.ev_data, 10'h11C);
    strobe(8'hE0, 0, 10'h0, 0);
    strobe(8'hF0, 0, 10'h0, 0);
    strobe(8'h75, 1, 10'h375, 0);
    chk("ext_brk_75", kif.ev_data, 10'h375);
    tick();

    // Pause: one event after the full 8-byte sequence.
    strobe(8'hE1, 0, 10'h0, 0);
    strobe(8'h14, 0, 10'h0, 0);
    strobe(8'h77, 0, 10'h0, 0);
    strobe(8'hE1, 0, 10'h0, 0);
    strobe(8'hF0, 0, 10'h0, 0);
    strobe(8'h14, 0, 10'h0, 0);
    strobe(8'hF0, 0, 10'h0, 0);
    strobe(8'h77, 1, 10'h2E1, 0);
    chk("pause", kif.ev_data, 10'h2E1);
    tick();

    // Timeout after E0: TMO idle cycles, then a plain make.
    strobe(8'hE0, 0, 10'h0, 0);
    repeat (TMO - 1) tick();
    exp_err = 1'b1;
    tick();
    exp_err = 1'b0;
    strobe(8'h1C, 1, 10'h01C, 0);
    chk("tmo_err", kif.err, 1'b1);
    chk("tmo_then_make", kif.ev_data, 10'h01C);
    kif.flag_clr = 1'b1;
    tick();
    kif.flag_clr = 1'b0;
    chk("err_cleared", kif.err, 1'b0);

    // Overflow: DEPTH+1 pushes with no consumer.
    kif.ev_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) strobe(8'h16, 1, 10'h016, 0);
    chk("full_rx_enable", kif.rx_enable, 1'b0);
    chk("ovf_set", kif.ovf, 1'b1);
    kif.ev_ready = 1'b1;
    repeat (DEPTH) tick();
    kif.ev_ready = 1'b0;
    chk("drained", kif.ev_valid, 1'b0);
    kif.flag_clr = 1'b1;
    tick();
    kif.flag_clr = 1'b0;
    chk("ovf_cleared", kif.ovf, 1'b0);

    // Push and pop together while full.
    for (int i = 0; i < DEPTH; i++) begin
      code = 8'h21 + 8'(i);
      strobe(code, 1, {2'b00, code}, 0);
    end
    kif.ev_ready = 1'b1;
    strobe(8'h1E, 1, 10'h01E, 0);
    kif.ev_ready = 1'b0;
    chk("pp_ovf", kif.ovf, 1'b0);
    chk("pp_still_full", kif.rx_enable, 1'b0);
    chk("pp_head", kif.ev_data, 10'h022);
    kif.ev_ready = 1'b1;
    repeat (DEPTH - 1) tick();
    chk("pp_last", kif.ev_data, 10'h01E);
    tick();
    kif.ev_ready = 1'b0;
    chk("pp_empty", kif.ev_valid, 1'b0);

    // Async reset mid-sequence and with a queued event.
    strobe(8'h00, 0, 10'h0, 1);
    strobe(8'h1C, 1, 10'h01C, 0);
    strobe(8'hF0, 0, 10'h0, 0);
    chk("pre_rst_err", kif.err, 1'b1);
    rst = 1'b1;
    #2;
    chk("async_rst_valid", kif.ev_valid, 1'b0);
    chk("async_rst_err", kif.err, 1'b0);
    tick();
    rst = 1'b0;
    kif.ev_ready = 1'b1;
    tick();
    strobe(8'h1C, 1, 10'h01C, 0);
    chk("post_rst_make", kif.ev_data, 10'h01C);

    // Overrun byte with a simultaneous clear: set wins.
    strobe(8'h00, 0, 10'h0, 1);
    chk("overrun_err", kif.err, 1'b1);
    kif.flag_clr = 1'b1;
    strobe(8'hFF, 0, 10'h0, 1);
    kif.flag_clr = 1'b0;
    chk("set_beats_clr", kif.err, 1'b1);
    kif.flag_clr = 1'b1;
    tick();
    kif.flag_clr = 1'b0;

    // F0 followed by E0 is malformed.
    strobe(8'hF0, 0, 10'h0, 0);
    strobe(8'hE0, 0, 10'h0, 1);
    strobe(8'h1C, 1, 10'h01C, 0);
    chk("brk_bad_recover", kif.ev_data, 10'h01C);

    // Dropping enable abandons a pending prefix.
    strobe(8'hE0, 0, 10'h0, 0);
    kif.enable = 1'b0;
    tick();
    kif.enable = 1'b1;
    strobe(8'h1C, 1, 10'h01C, 0);
    chk("enable_abort", kif.ev_data, 10'h01C);
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
